// File: rtl/multi_consumer_pipe_pkg.sv
// Shared constants, select-width helper and stage payload type for multi_consumer_pipe.
package multi_consumer_pipe_pkg;

   localparam int unsigned DEF_DATA_W    = 16;
   localparam int unsigned DEF_MAX_DEPTH = 8;
   localparam int unsigned DEF_NUM_TAPS  = 4;

   // Width of one tap select field; never narrower than one bit.
   function automatic int unsigned calc_sel_w(input int unsigned depth);
      int unsigned w;
      w = 32'($clog2(depth));
      return (w < 32'd1) ? 32'd1 : w;
   endfunction

   // One delay stage: valid flag plus sample at the default width.
   typedef struct packed {
      logic                  valid;
      logic [DEF_DATA_W-1:0] data;
   } stage_t;

endpackage

// File: rtl/multi_consumer_pipe_stage.sv
// mcp_stage: one {valid, data} register of the delay line.
// Reset and flush both clear the stage; otherwise it loads only when enabled.
module mcp_stage
   import multi_consumer_pipe_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic              i_flush,
   input  logic              i_v,
   input  logic [DATA_W-1:0] i_d,
   output logic              o_v,
   output logic [DATA_W-1:0] o_d
);

   logic              r_v;
   logic [DATA_W-1:0] r_d;

   // Stage register: reset beats flush, flush beats enable.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_v <= 1'b0;
         r_d <= '0;
      end else if (i_en) begin
         r_v <= i_v;
         r_d <= i_d;
      end
   end

   assign o_v = r_v;
   assign o_d = r_d;

endmodule

// File: rtl/multi_consumer_pipe.sv
// multi_consumer_pipe: en-qualified delay line with NUM_TAPS independent
// combinational taps. Optional valid-stage counter enabled by defining
// MULTI_CONSUMER_PIPE_FILL_COUNT_EN (adds the o_fill_count port).
module multi_consumer_pipe
   import multi_consumer_pipe_pkg::*;
#(
   parameter  int unsigned DATA_W    = DEF_DATA_W,
   parameter  int unsigned MAX_DEPTH = DEF_MAX_DEPTH,
   parameter  int unsigned NUM_TAPS  = DEF_NUM_TAPS,
`ifdef MULTI_CONSUMER_PIPE_FILL_COUNT_EN
   localparam int unsigned FC_W      = $clog2(MAX_DEPTH + 1),
`endif
   localparam int unsigned SEL_W     = calc_sel_w(MAX_DEPTH)
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_en,
   input  logic                       i_flush,
   input  logic [DATA_W-1:0]          i_d_in,
   input  logic                       i_v_in,
   input  logic [NUM_TAPS*SEL_W-1:0]  i_tap_sel,
   output logic [NUM_TAPS*DATA_W-1:0] o_d_out,
`ifdef MULTI_CONSUMER_PIPE_FILL_COUNT_EN
   output logic [NUM_TAPS-1:0]        o_v_out,
   output logic [FC_W-1:0]            o_fill_count
`else
   output logic [NUM_TAPS-1:0]        o_v_out
`endif
);

   // A select field can encode values past the last stage only when
   // MAX_DEPTH is not a power of two; only then is a clamp needed.
   localparam bit NEED_CLAMP = ((64'd1 << SEL_W) > 64'(MAX_DEPTH));

   logic [MAX_DEPTH-1:0] w_v;
   logic [DATA_W-1:0]    w_d [MAX_DEPTH];

   // Delay line: stage 0 takes the input sample, stage k takes stage k-1.
   for (genvar k = 0; k < int'(MAX_DEPTH); k++) begin : g_stage
      logic              w_vi;
      logic [DATA_W-1:0] w_di;

      if (k == 0) begin : g_head
         assign w_vi = i_v_in;
         assign w_di = i_d_in;
      end else begin : g_body
         assign w_vi = w_v[k-1];
         assign w_di = w_d[k-1];
      end

      mcp_stage #(
         .DATA_W (DATA_W)
      ) u_stage (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_en    (i_en),
         .i_flush (i_flush),
         .i_v     (w_vi),
         .i_d     (w_di),
         .o_v     (w_v[k]),
         .o_d     (w_d[k])
      );
   end

   // Tap muxes: unregistered stage select, clamped to the last stage.
   for (genvar t = 0; t < int'(NUM_TAPS); t++) begin : g_tap
      logic [SEL_W-1:0] w_raw;
      logic [SEL_W-1:0] w_idx;

      assign w_raw = i_tap_sel[t*SEL_W +: SEL_W];

      if (NEED_CLAMP) begin : g_clamp
         assign w_idx = (w_raw > SEL_W'(MAX_DEPTH - 1)) ? SEL_W'(MAX_DEPTH - 1) : w_raw;
      end else begin : g_pass
         assign w_idx = w_raw;
      end

      assign o_d_out[t*DATA_W +: DATA_W] = w_d[w_idx];
      assign o_v_out[t]                  = w_v[w_idx];
   end

`ifdef MULTI_CONSUMER_PIPE_FILL_COUNT_EN
   logic [FC_W-1:0] r_fill_count;

   // Valid-stage count: +1 for an entering valid, -1 for a valid leaving the end.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_fill_count <= '0;
      end else if (i_en) begin
         r_fill_count <= r_fill_count + FC_W'(i_v_in) - FC_W'(w_v[MAX_DEPTH-1]);
      end
   end

   assign o_fill_count = r_fill_count;
`endif

endmodule

// File: doc/multi_consumer_pipe.md
MULTI_CONSUMER_PIPE -- requirements
Module: multi_consumer_pipe

Interface
REQ-001 Parameter DATA_W, default 16: sample width in bits.
REQ-002 Parameter MAX_DEPTH, default 8: number of delay stages, legal range 2..64.
REQ-003 Parameter NUM_TAPS, default 4: number of independent consumer taps, legal range 1..16.
REQ-004 Derived constant SEL_W SHALL be clog2(MAX_DEPTH), with a minimum value of 1.
REQ-005 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 en  in  1  advance strobe; the line SHALL shift only when en=1.
REQ-008 flush  in  1  synchronous clear of line contents.
REQ-009 d_in  in  DATA_W  input sample.
REQ-010 v_in  in  1  input sample valid.
REQ-011 tap_sel  in  NUM_TAPS*SEL_W  per-tap delay select; field i = required delay minus 1.
REQ-012 d_out  out  NUM_TAPS*DATA_W  per-tap delayed data; field i belongs to tap i.
REQ-013 v_out  out  NUM_TAPS  per-tap valid.
REQ-014 fill_count  out  clog2(MAX_DEPTH+1)  count of valid stages; present only under the REQ-030 macro.

Function
REQ-015 Stage array stg[0..MAX_DEPTH-1]; each stage SHALL hold {valid, data}.
REQ-016 On a clock edge with en=1 and flush=0, stg[0] SHALL load {v_in, d_in} and each stg[k] SHALL load stg[k-1].
REQ-017 With en=0 and flush=0, every stage SHALL hold its value, including while v_in=1.
REQ-018 Tap i SHALL drive stg[min(tap_sel_i, MAX_DEPTH-1)]; out-of-range selects clamp to the last stage.
REQ-019 Tap outputs SHALL be a combinational mux of stage registers: delay = tap_sel_i+1 en-qualified edges, with no extra output register.
REQ-020 A tap_sel change SHALL take effect in the same cycle; no state is reset.
REQ-021 Several taps MAY select the same stage; each tap SHALL then present identical d_out and v_out.
REQ-022 flush=1 SHALL zero every stage's valid and data on the next edge, regardless of en.
REQ-023 When flush and en=1 coincide, flush SHALL win and the incoming sample SHALL be dropped.
REQ-024 Data SHALL pass bit-exact; there is no width conversion and no arithmetic on data.
REQ-025 The valid of the oldest sample SHALL be discarded when it shifts out of stg[MAX_DEPTH-1]; there is no backpressure output.

Reset
REQ-026 rst=1 SHALL clear all stage valid and data bits to 0 on the next rising edge.
REQ-027 After reset, d_out SHALL be 0, v_out SHALL be 0 and fill_count SHALL be 0.
REQ-028 rst SHALL override en and flush.
REQ-029 A reset asserted mid-stream SHALL discard all in-flight samples, with no partial shift.

Configuration
REQ-030 Macro MULTI_CONSUMER_PIPE_FILL_COUNT_EN defined: the fill_count port and its logic SHALL exist.
REQ-031 fill_count update on an en edge: fill_count + v_in - stg[MAX_DEPTH-1].valid.
REQ-032 fill_count SHALL be 0 on flush or rst and held when en=0.
REQ-033 fill_count SHALL never exceed MAX_DEPTH.
REQ-034 Macro undefined: the port SHALL be absent and no counter logic inferred; all other behaviour SHALL be identical.

Structure
REQ-035 Package multi_consumer_pipe_pkg SHALL hold the default DATA_W, MAX_DEPTH and NUM_TAPS constants, the SEL_W derivation function and a stage_t typedef {valid, data}.
REQ-036 One sub-module, mcp_stage, SHALL implement a single enable/flush/reset register stage; the top SHALL instantiate MAX_DEPTH of them through a generate loop.
REQ-037 Tap muxes and the fill counter SHALL reside in the top module.

Verification
REQ-038 Defaults with taps {0,1,3,6}, en=1, v_in=1, rst released after 1 cycle, d_in=FFFF for 2 cycles then 00FF for 2 then 0000 -> FFFF SHALL appear on taps at delays 1, 2, 4 and 7; v_out bits SHALL rise in that order.
REQ-039 en toggled 1,0,1,0 with ramp data 0001.. and tap_sel=2 -> output SHALL advance only on en=1 edges; 0001 SHALL appear after the third en edge.
REQ-040 Line full of valid data, flush and en both 1 with d_in=ABCD -> next cycle all v_out=0, all d_out=0, fill_count=0, and ABCD SHALL never appear.
REQ-041 tap_sel=7 with MAX_DEPTH=6 -> the tap SHALL track stg[5], matching a tap_sel=5 tap every cycle.
REQ-042 Macro defined, v_in pattern 1,0,1,1 over MAX_DEPTH+4 en cycles -> fill_count SHALL equal the reference-model popcount every cycle and SHALL never exceed 8.
REQ-043 rst pulsed for 1 cycle mid-stream -> next cycle all outputs 0, and streaming SHALL resume cleanly with new samples.
